// File: rtl/ripple_carry_adder_borrow_subtractor.sv
// Unsigned ripple-carry adder/subtractor with a one-cycle registered output stage.
// Optional signed-overflow output is enabled by defining RCA_SIGNED_OVERFLOW_EN.
module ripple_carry_adder_borrow_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
`ifdef RCA_SIGNED_OVERFLOW_EN
    output logic             overflow,
`endif
    output logic [WIDTH-1:0] result,
    output logic             carry_borrow,
    output logic             out_valid
);

    // Single full-adder cell: {carry_out, sum}
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic cin);
        full_add = {(x & y) | (x & cin) | (y & cin), x ^ y ^ cin};
    endfunction

    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH-1:0] w_sum;
    logic             w_carry_borrow;
    logic             w_overflow;

    logic [WIDTH-1:0] r_result;
    logic             r_carry_borrow;
    logic             r_out_valid;
    logic             r_overflow;

    // Carry-in of mode plus inverted b implements two's-complement subtraction.
    assign w_carry[0] = mode;
    assign w_b_eff    = b ^ {WIDTH{mode}};

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            assign {w_carry[gi+1], w_sum[gi]} = full_add(a[gi], w_b_eff[gi], w_carry[gi]);
        end
    endgenerate

    // A missing carry-out during subtraction means the minuend was smaller.
    assign w_carry_borrow = w_carry[WIDTH] ^ mode;
    assign w_overflow     = w_carry[WIDTH] ^ w_carry[WIDTH-1];

    // Output register: reset wins, valid operations load, idle cycles hold data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_result       <= {WIDTH{1'b0}};
            r_carry_borrow <= 1'b0;
            r_overflow     <= 1'b0;
            r_out_valid    <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_result       <= w_sum;
                r_carry_borrow <= w_carry_borrow;
                r_overflow     <= w_overflow;
            end else begin
                r_result       <= r_result;
                r_carry_borrow <= r_carry_borrow;
                r_overflow     <= r_overflow;
            end
        end
    end

    assign result       = r_result;
    assign carry_borrow = r_carry_borrow;
    assign out_valid    = r_out_valid;

`ifdef RCA_SIGNED_OVERFLOW_EN
    assign overflow = r_overflow;
`else
    logic w_unused_ovf;
    assign w_unused_ovf = r_overflow;
`endif

endmodule

// File: tb/tb_ripple_carry_adder_borrow_subtractor.sv
// Self-checking bench: directed plan vectors plus randomized and exhaustive runs
// compared against an arithmetic reference model.
module tb_ripple_carry_adder_borrow_subtractor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       in_valid, mode;
    logic [3:0] a, b;
    wire  [3:0] result;
    wire        carry_borrow, out_valid;

    logic       in_valid8, mode8;
    logic [7:0] a8, b8;
    wire  [7:0] result8;
    wire        carry_borrow8, out_valid8;

`ifdef RCA_SIGNED_OVERFLOW_EN
    wire overflow, overflow8;
`endif

    ripple_carry_adder_borrow_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .mode(mode),
`ifdef RCA_SIGNED_OVERFLOW_EN
        .overflow(overflow),
`endif
        .result(result), .carry_borrow(carry_borrow), .out_valid(out_valid));

    ripple_carry_adder_borrow_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .a(a8), .b(b8), .mode(mode8),
`ifdef RCA_SIGNED_OVERFLOW_EN
        .overflow(overflow8),
`endif
        .result(result8), .carry_borrow(carry_borrow8), .out_valid(out_valid8));

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state for the 4-bit instance (what the outputs should hold).
    logic [3:0] m_res;
    logic       m_cb, m_ovf, m_vld;

    task automatic step4(input logic v, input logic [3:0] av, input logic [3:0] bv, input logic m);
        int s, sa, sb, ss;
        @(negedge clk);
        in_valid = v; a = av; b = bv; mode = m;
        in_valid8 = 1'b0;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_res = 4'd0; m_cb = 1'b0; m_ovf = 1'b0; m_vld = 1'b0;
        end else begin
            m_vld = v;
            if (v) begin
                s     = m ? (int'(av) - int'(bv)) : (int'(av) + int'(bv));
                m_res = 4'(s & 15);
                m_cb  = m ? (av < bv) : (s > 15);
                sa    = (av >= 4'd8) ? int'(av) - 16 : int'(av);
                sb    = (bv >= 4'd8) ? int'(bv) - 16 : int'(bv);
                ss    = m ? sa - sb : sa + sb;
                m_ovf = (ss > 7) || (ss < -8);
            end
        end
    endtask

    task automatic step8(input logic [7:0] av, input logic [7:0] bv, input logic m);
        @(negedge clk);
        in_valid8 = 1'b1; a8 = av; b8 = bv; mode8 = m;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        m_vld = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step4(1'b1, 4'hF, 4'h1, 1'b0);
            tests_run++;
            if ({out_valid, carry_borrow, result} !== 6'b0) begin
                tests_failed++;
                $display("FAIL reset cycle %0d: got v=%b cb=%b r=%h, want 0/0/0",
                         i, out_valid, carry_borrow, result);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_add_sweep;
        logic [3:0] ta [4] = '{4'h0, 4'hF, 4'hF, 4'h7};
        logic [3:0] tb [4] = '{4'h0, 4'h1, 4'hF, 4'h1};
        logic [4:0] te [4] = '{5'b0_0000, 5'b1_0000, 5'b1_1110, 5'b0_1000};
        for (int i = 0; i < 4; i++) begin
            step4(1'b1, ta[i], tb[i], 1'b0);
            tests_run++;
            if ({out_valid, carry_borrow, result} !== {1'b1, te[i]}) begin
                tests_failed++;
                $display("FAIL add %h+%h: got v=%b cb=%b r=%b, want 1/%b/%b",
                         ta[i], tb[i], out_valid, carry_borrow, result, te[i][4], te[i][3:0]);
            end
        end
    endtask

    task automatic test_subtract_back_to_back;
        logic [3:0] ta [3] = '{4'hA, 4'h0, 4'h0};
        logic [3:0] tb [3] = '{4'hA, 4'h1, 4'hF};
        logic [4:0] te [3] = '{5'b0_0000, 5'b1_1111, 5'b1_0001};
        for (int i = 0; i < 3; i++) begin
            step4(1'b1, ta[i], tb[i], 1'b1);
            tests_run++;
            if ({out_valid, carry_borrow, result} !== {1'b1, te[i]}) begin
                tests_failed++;
                $display("FAIL sub %h-%h: got v=%b cb=%b r=%b, want 1/%b/%b",
                         ta[i], tb[i], out_valid, carry_borrow, result, te[i][4], te[i][3:0]);
            end
        end
    endtask

    task automatic test_hold;
        step4(1'b1, 4'hF, 4'h1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step4(1'b0, 4'h3, 4'h3, 1'b0);
            tests_run++;
            if ({out_valid, carry_borrow, result} !== 6'b0_1_0000) begin
                tests_failed++;
                $display("FAIL hold cycle %0d: got v=%b cb=%b r=%b, want 0/1/0000",
                         i, out_valid, carry_borrow, result);
            end
        end
    endtask

    task automatic test_reset_mid_stream;
        step4(1'b1, 4'h9, 4'h9, 1'b0);
        rst_n = 1'b0;
        step4(1'b1, 4'hF, 4'hF, 1'b0);
        rst_n = 1'b1;
        step4(1'b0, 4'h1, 4'h1, 1'b0);
        tests_run++;
        if ({out_valid, carry_borrow, result} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_stream: got v=%b cb=%b r=%b, want 0/0/0000",
                     out_valid, carry_borrow, result);
        end
    endtask

    task automatic test_exhaustive;
        for (int m = 0; m < 2; m++)
            for (int x = 0; x < 16; x++)
                for (int y = 0; y < 16; y++) begin
                    step4(1'b1, 4'(x), 4'(y), 1'(m));
                    tests_run++;
                    if ({out_valid, carry_borrow, result} !== {m_vld, m_cb, m_res}) begin
                        tests_failed++;
                        $display("FAIL exhaustive %0d%s%0d: got v=%b cb=%b r=%h, want %b/%b/%h",
                                 x, m ? "-" : "+", y, out_valid, carry_borrow, result,
                                 m_vld, m_cb, m_res);
                    end
`ifdef RCA_SIGNED_OVERFLOW_EN
                    tests_run++;
                    if (overflow !== m_ovf) begin
                        tests_failed++;
                        $display("FAIL exhaustive_ovf %0d%s%0d: got %b want %b",
                                 x, m ? "-" : "+", y, overflow, m_ovf);
                    end
`endif
                end
    endtask

    task automatic test_random;
        for (int i = 0; i < 300; i++) begin
            step4(1'($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom), 1'($urandom));
            tests_run++;
            if ({out_valid, carry_borrow, result} !== {m_vld, m_cb, m_res}) begin
                tests_failed++;
                $display("FAIL random %0d: got v=%b cb=%b r=%h, want %b/%b/%h",
                         i, out_valid, carry_borrow, result, m_vld, m_cb, m_res);
            end
        end
    endtask

    task automatic test_width8;
        int s;
        logic [7:0] xa, xb;
        logic       xm;
        step8(8'hFF, 8'h01, 1'b0);
        tests_run++;
        if ({out_valid8, carry_borrow8, result8} !== {1'b1, 1'b1, 8'h00}) begin
            tests_failed++;
            $display("FAIL w8 FF+01: got v=%b cb=%b r=%h, want 1/1/00",
                     out_valid8, carry_borrow8, result8);
        end
        step8(8'h00, 8'h01, 1'b1);
        tests_run++;
        if ({out_valid8, carry_borrow8, result8} !== {1'b1, 1'b1, 8'hFF}) begin
            tests_failed++;
            $display("FAIL w8 00-01: got v=%b cb=%b r=%h, want 1/1/FF",
                     out_valid8, carry_borrow8, result8);
        end
        for (int i = 0; i < 50; i++) begin
            xa = 8'($urandom); xb = 8'($urandom); xm = 1'($urandom);
            step8(xa, xb, xm);
            s = xm ? int'(xa) - int'(xb) : int'(xa) + int'(xb);
            tests_run++;
            if ({carry_borrow8, result8} !== {(xm ? (xa < xb) : (s > 255)), 8'(s & 255)}) begin
                tests_failed++;
                $display("FAIL w8 random %h%s%h: got cb=%b r=%h", xa, xm ? "-" : "+", xb,
                         carry_borrow8, result8);
            end
        end
    endtask

`ifdef RCA_SIGNED_OVERFLOW_EN
    task automatic test_overflow;
        logic [3:0] ta [3] = '{4'h7, 4'h8, 4'hF};
        logic [3:0] tb [3] = '{4'h1, 4'h1, 4'h1};
        logic       tm [3] = '{1'b0, 1'b1, 1'b0};
        logic       te [3] = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            step4(1'b1, ta[i], tb[i], tm[i]);
            tests_run++;
            if (overflow !== te[i]) begin
                tests_failed++;
                $display("FAIL overflow %h%s%h: got %b want %b",
                         ta[i], tm[i] ? "-" : "+", tb[i], overflow, te[i]);
            end
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = 4'd0; b = 4'd0; mode = 1'b0;
        in_valid8 = 1'b0; a8 = 8'd0; b8 = 8'd0; mode8 = 1'b0;
        m_res = 4'd0; m_cb = 1'b0; m_ovf = 1'b0; m_vld = 1'b0;
        test_reset;
        test_add_sweep;
        test_subtract_back_to_back;
        test_hold;
        test_reset_mid_stream;
        test_exhaustive;
        test_random;
        test_width8;
`ifdef RCA_SIGNED_OVERFLOW_EN
        test_overflow;
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
